// File: rtl/he_pkg.sv
// Shared definitions for the modular-arithmetic streaming blocks.
package he_pkg;

    localparam int unsigned DEF_Q = 7681;
    localparam int unsigned DEF_N = 256;
    localparam int unsigned DEF_W = $clog2(DEF_Q);

    typedef enum logic [1:0] {
        WAIT_INV = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    typedef logic [DEF_W-1:0] coeff_t;

endpackage

// File: rtl/mod_mult.sv
// Two-stage modular multiplier: full-width product, then reduction mod Q.
// Both stages advance only when i_en is high.
module mod_mult
    import he_pkg::*;
#(
    parameter int unsigned Q = DEF_Q,
    parameter int unsigned W = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] r_p1;
    logic          r_v1;
    logic [W-1:0]  r_data;
    logic          r_valid;

    // Stage 1: product kept at full 2W bits so unreduced inputs stay exact.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p1 <= '0;
            r_v1 <= 1'b0;
        end else if (i_en) begin
            if (i_load) begin
                r_p1 <= PW'(i_a) * PW'(i_b);
                r_v1 <= 1'b1;
            end else begin
                r_v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= W'(r_p1 % PW'(Q));
            r_valid <= r_v1;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/inv_scale_stream.sv
// Latches a modular inverse and scales a frame of N coefficients by it mod Q,
// with valid/ready on both sides and a done pulse per frame.
module inv_scale_stream
    import he_pkg::*;
#(
    parameter int unsigned Q  = DEF_Q,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned W  = $clog2(Q),
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inv_valid,
    input  logic [W-1:0] i_inv_in,
    output logic         o_inv_err,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned WX = W + 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_inv;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_out_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_inv_err;

    logic          w_en;
    logic          w_accept;
    logic          w_out_hs;
    logic          w_inv_ok;
    logic          w_inv_take;
    logic          w_last_out;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;

    // Whole pipeline stalls only when the output register is full and not taken.
    assign w_en       = !o_out_valid || i_out_ready;
    assign o_in_ready = (r_state == STREAM) && w_en && (r_in_cnt != CW'(N));
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_out_hs   = o_out_valid && i_out_ready;
    assign w_inv_ok   = (i_inv_in != '0) && (WX'(i_inv_in) < WX'(Q));
    assign w_last_out = w_out_hs && (r_out_cnt == CW'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_inv_take  = 1'b0;
        case (r_state)
            WAIT_INV: begin
                if (i_inv_valid) begin
                    if (w_inv_ok) begin
                        w_inv_take  = 1'b1;
                        w_state_nxt = STREAM;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (r_in_cnt == CW'(N)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_out) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = WAIT_INV;
                end
            end
            default: w_state_nxt = WAIT_INV;
        endcase
        w_busy_nxt = (w_state_nxt != WAIT_INV);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= WAIT_INV;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_inv_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_inv_err <= w_err_nxt;
        end
    end

    // Inverse latch and frame counters; both counters restart with each new inverse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inv     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_inv_take) begin
            r_inv     <= i_inv_in;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + CW'(1);
            end
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end
        end
    end

    mod_mult #(
        .Q(Q),
        .W(W)
    ) u_mod_mult (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_en),
        .i_load  (w_accept),
        .i_a     (i_in_data),
        .i_b     (r_inv),
        .o_valid (o_out_valid),
        .o_data  (o_out_data)
    );

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_inv_err = r_inv_err;

endmodule

// File: tb/tb_inv_scale_stream.sv
// Scoreboard bench for inv_scale_stream with Q=17, N=4 and a behavioural model.
module tb_inv_scale_stream;

    localparam int unsigned TQ  = 17;
    localparam int unsigned TN  = 4;
    localparam int unsigned TW  = 5;
    localparam int unsigned TCW = 3;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_inv_valid = 1'b0;
    logic [TW-1:0] i_inv_in = '0;
    logic          o_inv_err;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [TW-1:0] i_in_data = '0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [TW-1:0] o_out_data;
    logic          o_busy;
    logic          o_done;

    int checks    = 0;
    int failures  = 0;
    int exp_q[$];
    int cyc       = 0;
    int first_acc = -1;
    int first_out = -1;
    int omode     = 0;
    int ocnt      = 0;

    always #5 clk = ~clk;

    inv_scale_stream #(
        .Q (TQ),
        .N (TN),
        .W (TW),
        .CW(TCW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_inv_valid (i_inv_valid),
        .i_inv_in    (i_inv_in),
        .o_inv_err   (o_inv_err),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 steady, 1 pattern 1,0,0,1, 2 random, 3 held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (omode)
                0: i_out_ready = 1'b1;
                1: begin
                    i_out_ready = ((ocnt % 4) == 0) || ((ocnt % 4) == 3);
                    ocnt++;
                end
                2: i_out_ready = 1'($urandom_range(0, 1));
                default: i_out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and tracks done timing.
    initial begin
        int  mon_cnt;
        bit  exp_done;
        bit  prev_stall;
        int  prev_data;
        int  e;
        mon_cnt    = 0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                exp_q.delete();
                mon_cnt    = 0;
                exp_done   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("done_timing", int'(o_done), int'(exp_done));
                if (o_done) check("busy_at_done", int'(o_busy), 0);
                exp_done = 1'b0;
                if (prev_stall) begin
                    check("stall_valid_hold", int'(o_out_valid), 1);
                    check("stall_data_hold", int'(o_out_data), prev_data);
                end
                if (o_out_valid && first_out < 0) first_out = cyc;
                if (o_out_valid && i_out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected: got %0d expected nothing", o_out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", int'(o_out_data), e);
                    end
                    mon_cnt++;
                    if (mon_cnt == int'(TN)) begin
                        exp_done = 1'b1;
                        mon_cnt  = 0;
                    end
                end
                prev_stall = o_out_valid && !i_out_ready;
                prev_data  = int'(o_out_data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input int inv);
        int waited = 0;
        i_in_valid = 1'b1;
        i_in_data  = TW'(d);
        while (!o_in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (o_in_ready) begin
            exp_q.push_back((d * inv) % int'(TQ));
            if (first_acc < 0) first_acc = cyc;
        end else begin
            check("accept_timeout", int'(o_in_ready), 1);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic offer_inv(input int inv);
        i_inv_valid = 1'b1;
        i_inv_in    = TW'(inv);
        @(negedge clk);
        i_inv_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w = 0;
        while (!o_done && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", int'(o_done), 1);
    endtask

    task automatic rand_frame(input int inv, input bit gaps);
        for (int i = 0; i < int'(TN); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
            end
            send(int'($urandom_range(0, 31)), inv);
        end
    endtask

    initial begin
        int c0;
        int inv;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_out_data", int'(o_out_data), 0);
        check("rst_in_ready", int'(o_in_ready), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_inv_err", int'(o_inv_err), 0);
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);

        // Basic frame, 5 1 16 0 scaled by 6 mod 17.
        omode     = 0;
        first_acc = -1;
        first_out = -1;
        offer_inv(6);
        check("first_in_ready", int'(o_in_ready), 1);
        check("busy_stream", int'(o_busy), 1);
        c0 = cyc;
        send(5, 6);
        send(1, 6);
        send(16, 6);
        send(0, 6);
        check("throughput_cycles", cyc - c0, int'(TN));
        wait_done();
        check("latency", first_out - first_acc, 2);

        // Backpressure with ready pattern 1,0,0,1.
        @(negedge clk);
        ocnt  = 0;
        omode = 1;
        offer_inv(6);
        send(5, 6);
        send(1, 6);
        send(16, 6);
        send(0, 6);
        wait_done();

        // Rejected inverses.
        omode = 0;
        @(negedge clk);
        offer_inv(0);
        check("err_zero", int'(o_inv_err), 1);
        check("err_zero_ready", int'(o_in_ready), 0);
        @(negedge clk);
        check("err_pulse_len", int'(o_inv_err), 0);
        offer_inv(17);
        check("err_q", int'(o_inv_err), 1);
        check("err_q_ready", int'(o_in_ready), 0);
        check("err_q_busy", int'(o_busy), 0);
        offer_inv(6);
        check("accept_no_err", int'(o_inv_err), 0);
        send(20, 6);
        send(31, 6);
        send(17, 6);
        send(3, 6);
        wait_done();

        // Reset mid-frame after two accepts.
        @(negedge clk);
        offer_inv(9);
        send(7, 9);
        send(12, 9);
        omode = 3;
        @(posedge clk);
        #1 i_reset = 1'b1;
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", int'(o_out_valid), 0);
        check("mid_rst_out_data", int'(o_out_data), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_in_ready", int'(o_in_ready), 0);
        check("mid_rst_done", int'(o_done), 0);
        omode = 0;
        repeat (3) @(negedge clk);
        check("mid_rst_idle_ready", int'(o_in_ready), 0);
        offer_inv(11);
        rand_frame(11, 1'b0);
        wait_done();

        // Back-to-back frames: next inverse offered in the done cycle.
        offer_inv(13);
        check("b2b_busy", int'(o_busy), 1);
        check("b2b_in_ready", int'(o_in_ready), 1);
        rand_frame(13, 1'b0);
        wait_done();

        // Random frames under random backpressure and input gaps.
        omode = 2;
        for (int f = 0; f < 12; f++) begin
            inv = int'($urandom_range(1, TQ - 1));
            offer_inv(inv);
            rand_frame(inv, 1'b1);
            wait_done();
        end

        omode = 0;
        repeat (5) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("end_busy", int'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
